testdrive_slave_mailbox: RTL
============================

// Module: testdrive_slave_mailbox
// PURPOSE
//  - Register-bank consumer for a virtual slave strobe bus (WE/WADDR/WDATA, RE/RADDR -> RDATA).
//  - Turns host writes to TX_DATA into a buffered valid/ready stream (TX) toward user logic.
//  - Buffers a user valid/ready stream (RX) for host reads of RX_DATA; adds CTRL/STATUS/SCRATCH regs.
// PARAMETERS
//  C_ADDR_BITS      10  word-address width of WADDR/RADDR
//  C_TX_DEPTH_LOG2  4   TX FIFO depth = 2**N entries, legal range 1..7
//  C_RX_DEPTH_LOG2  4   RX FIFO depth = 2**N entries, legal range 1..7
// PORTS
//  CLK       in   1            single clock, all logic on posedge
//  RST       in   1            synchronous reset, active-high
//  WE        in   1            host write strobe, one word per cycle
//  WADDR     in   C_ADDR_BITS  host write word address
//  WDATA     in   32           host write data
//  RE        in   1            host read strobe
//  RADDR     in   C_ADDR_BITS  host read word address
//  RDATA     out  32           read data, registered
//  TX_VALID  out  1            TX stream data available (TX FIFO not empty)
//  TX_READY  in   1            TX consumer accepts head word
//  TX_DATA   out  32           TX FIFO head word
//  RX_VALID  in   1            RX producer offers word
//  RX_READY  out  1            RX FIFO not full
//  RX_DATA   in   32           RX word
//  IRQ       out  1            level interrupt, present only with SLAVE_MAILBOX_IRQ_EN
// BEHAVIOUR
//  - Map (word addr): 0 CTRL rw | 1 STATUS ro/w1c | 2 TX_DATA wo | 3 RX_DATA ro | 4 SCRATCH rw.
//    Addr >=5: writes ignored, reads return 0. Full WADDR/RADDR decoded, no aliasing.
//  - Reset: RDATA=0, CTRL=0, SCRATCH=0, both FIFOs empty, sticky flags 0, TX_VALID=0, RX_READY=1, IRQ=0.
//  - Read latency 1: RE in cycle n -> RDATA valid cycle n+1; RDATA holds its value while RE=0.
//  - CTRL: [0] TX_FLUSH, [1] RX_FLUSH (self-clearing, read 0). The flush empties the FIFO in the
//    write cycle; it wins over same-cycle push/pop on that FIFO. [9:8] IRQ enables (see CONFIGURATION).
//  - STATUS: [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full [4] TX_OVF [5] RX_UDF
//    [15:8] tx_count [23:16] rx_count, zero-extended. Writing 1 to bit 4 or 5 clears that bit.
//  - TX_DATA write: push if not full. If full: drop the word, set TX_OVF.
//    A same-cycle TX pop (TX_VALID&TX_READY) does NOT free space for that push.
//  - RX_DATA read: pop head into RDATA. If empty: RDATA=0, set RX_UDF.
//    RX push (RX_VALID&RX_READY) plus pop in the same cycle: count unchanged, data order kept.
//  - TX stream: TX_DATA = head; pop on TX_VALID&TX_READY; push+pop same cycle keeps count.
//  - Sticky set and W1C in the same cycle: set wins.
//  - WE and RE in the same cycle are both serviced. A read of STATUS returns the value before
//    that cycle's updates.
//  - RST mid-transfer: FIFOs emptied; stream handshakes deasserted in the cycle after RST.
//  - Pointers wrap modulo depth. Counts are depth_log2+1 bits, saturating at depth (full).
// CONFIGURATION
//  - SLAVE_MAILBOX_IRQ_EN defined: IRQ port exists; CTRL[8] RX_IRQ_EN, CTRL[9] ERR_IRQ_EN.
//    IRQ registered = (CTRL[8] & !rx_empty) | (CTRL[9] & (TX_OVF|RX_UDF)), 1-cycle lag.
//  - Undefined: no IRQ port; CTRL[9:8] read 0, writes ignored.
// STRUCTURE
//  - Package testdrive_slave_mailbox_pkg: register offsets (ADDR_CTRL..ADDR_SCRATCH),
//    CTRL/STATUS bit-index localparams, packed struct typedef for STATUS.
//  - Sub-module testdrive_sync_fifo (params DATA_W, DEPTH_LOG2; push/pop/flush, count,
//    full/empty), instantiated twice (TX, RX). Top holds decode, regs, sticky flags, RDATA mux.
// TESTING
//  - Reset: hold RST 2 cycles -> RDATA=0, STATUS read = 0x0000_0005, TX_VALID=0, RX_READY=1.
//  - Write SCRATCH 0xDEADBEEF, read addr 4 -> RDATA=0xDEADBEEF exactly 1 cycle after RE;
//    read addr 7 -> 0.
//  - TX_READY=0, write 17 words 1..17 to TX_DATA (depth 16) -> tx_full, TX_OVF=1, word 17 lost.
//    Raise TX_READY -> TX_DATA order 1..16; W1C 0x10 clears TX_OVF.
//  - Push RX 0xA5 via RX_VALID; read RX_DATA twice -> 0xA5, then 0 with RX_UDF=1.
//    Push and pop in the same cycle -> rx_count unchanged.
//  - Fill RX with 3 words, write CTRL=0x2 together with RX_VALID=1 -> rx_count=0, CTRL reads 0.
//  - With SLAVE_MAILBOX_IRQ_EN: CTRL=0x100, push one RX word -> IRQ=1 next cycle;
//    pop that word -> IRQ=0.

Source files
------------

// File: rtl/testdrive_slave_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// testdrive_slave_mailbox_pkg
//   Shared definitions for the slave mailbox:
//   - Word offsets of the host-visible registers.
//   - Bit indices inside CTRL and STATUS.
//   - Packed layout of the STATUS word.
// -----------------------------------------------------------------------------
package testdrive_slave_mailbox_pkg;

   // Register word offsets
   localparam int unsigned ADDR_CTRL    = 0;
   localparam int unsigned ADDR_STATUS  = 1;
   localparam int unsigned ADDR_TX_DATA = 2;
   localparam int unsigned ADDR_RX_DATA = 3;
   localparam int unsigned ADDR_SCRATCH = 4;

   // CTRL bit indices
   localparam int unsigned CTRL_TX_FLUSH   = 0;
   localparam int unsigned CTRL_RX_FLUSH   = 1;
   localparam int unsigned CTRL_RX_IRQ_EN  = 8;
   localparam int unsigned CTRL_ERR_IRQ_EN = 9;

   // STATUS bit indices for the write-1-to-clear sticky flags
   localparam int unsigned STAT_TX_OVF = 4;
   localparam int unsigned STAT_RX_UDF = 5;

   // STATUS word, MSB first
   typedef struct packed {
      logic [7:0] rsvd_hi;
      logic [7:0] rx_count;
      logic [7:0] tx_count;
      logic [1:0] rsvd_lo;
      logic       rx_udf;
      logic       tx_ovf;
      logic       rx_full;
      logic       rx_empty;
      logic       tx_full;
      logic       tx_empty;
   } status_t;

endpackage

// File: rtl/testdrive_sync_fifo.sv
// -----------------------------------------------------------------------------
// testdrive_sync_fifo
//   Single-clock FIFO with a combinational head output (show-ahead).
//   Push is ignored when full and pop is ignored when empty, judged on the
//   state before the edge, so a pop never makes room for a same-cycle push.
//   Flush empties the FIFO and overrides any same-cycle push or pop.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push, din       write request and data
//     pop             remove head word
//     flush           empty the FIFO
//     dout            head word (only meaningful while !empty)
//     count           occupancy, 0..2**DEPTH_LOG2
//     full, empty     occupancy flags
// -----------------------------------------------------------------------------
module testdrive_sync_fifo #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are exactly DEPTH_LOG2 bits, so increment wraps modulo depth.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; validity is tracked by the pointers and
   // count alone, which keeps the array as plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/testdrive_slave_mailbox.sv
// -----------------------------------------------------------------------------
// testdrive_slave_mailbox
//   Register-bank consumer on a simple strobe bus. Host writes to TX_DATA feed
//   a TX valid/ready stream; an RX valid/ready stream is buffered for host
//   reads of RX_DATA. Also provides CTRL, STATUS (sticky W1C flags) and SCRATCH.
//   Optional feature macro: SLAVE_MAILBOX_IRQ_EN adds the IRQ output and the
//   CTRL[9:8] interrupt enables; without it those bits read 0.
//   Ports:
//     CLK, RST                clock, synchronous active-high reset
//     WE, WADDR, WDATA        host write strobe / word address / data
//     RE, RADDR, RDATA        host read strobe / word address / registered data
//     TX_VALID/READY/DATA     outbound stream (FIFO head)
//     RX_VALID/READY/DATA     inbound stream
//     IRQ                     level interrupt (SLAVE_MAILBOX_IRQ_EN only)
// -----------------------------------------------------------------------------
module testdrive_slave_mailbox
   import testdrive_slave_mailbox_pkg::*;
#(
   parameter int C_ADDR_BITS     = 10,
   parameter int C_TX_DEPTH_LOG2 = 4,
   parameter int C_RX_DEPTH_LOG2 = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   WE,
   input  logic [C_ADDR_BITS-1:0] WADDR,
   input  logic [31:0]            WDATA,
   input  logic                   RE,
   input  logic [C_ADDR_BITS-1:0] RADDR,
   output logic [31:0]            RDATA,
   output logic                   TX_VALID,
   input  logic                   TX_READY,
   output logic [31:0]            TX_DATA,
   input  logic                   RX_VALID,
   output logic                   RX_READY,
   input  logic [31:0]            RX_DATA
`ifdef SLAVE_MAILBOX_IRQ_EN
   ,
   output logic                   IRQ
`endif
);

   localparam logic [C_ADDR_BITS-1:0] A_CTRL    = C_ADDR_BITS'(ADDR_CTRL);
   localparam logic [C_ADDR_BITS-1:0] A_STATUS  = C_ADDR_BITS'(ADDR_STATUS);
   localparam logic [C_ADDR_BITS-1:0] A_TX_DATA = C_ADDR_BITS'(ADDR_TX_DATA);
   localparam logic [C_ADDR_BITS-1:0] A_RX_DATA = C_ADDR_BITS'(ADDR_RX_DATA);
   localparam logic [C_ADDR_BITS-1:0] A_SCRATCH = C_ADDR_BITS'(ADDR_SCRATCH);

   // Full-width decode: no aliasing of upper address bits.
   logic wr_ctrl, wr_status, wr_tx, wr_scratch, rd_rx;
   assign wr_ctrl    = WE && (WADDR == A_CTRL);
   assign wr_status  = WE && (WADDR == A_STATUS);
   assign wr_tx      = WE && (WADDR == A_TX_DATA);
   assign wr_scratch = WE && (WADDR == A_SCRATCH);
   assign rd_rx      = RE && (RADDR == A_RX_DATA);

   logic tx_flush, rx_flush;
   assign tx_flush = wr_ctrl && WDATA[CTRL_TX_FLUSH];
   assign rx_flush = wr_ctrl && WDATA[CTRL_RX_FLUSH];

   // ---------------------------------------------------------------- FIFOs
   logic [C_TX_DEPTH_LOG2:0] tx_count;
   logic [C_RX_DEPTH_LOG2:0] rx_count;
   logic                     tx_full, tx_empty, rx_full, rx_empty;
   logic [31:0]              rx_head;

   assign TX_VALID = !tx_empty;
   assign RX_READY = !rx_full;

   testdrive_sync_fifo #(
      .DATA_W     (32),
      .DEPTH_LOG2 (C_TX_DEPTH_LOG2)
   ) u_tx_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (wr_tx),
      .pop   (TX_VALID && TX_READY),
      .flush (tx_flush),
      .din   (WDATA),
      .dout  (TX_DATA),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   testdrive_sync_fifo #(
      .DATA_W     (32),
      .DEPTH_LOG2 (C_RX_DEPTH_LOG2)
   ) u_rx_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (RX_VALID && RX_READY),
      .pop   (rd_rx),
      .flush (rx_flush),
      .din   (RX_DATA),
      .dout  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // ------------------------------------------------------- sticky flags
   logic tx_ovf, rx_udf;

   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
      end else begin
         // A new error event in the same cycle as the W1C keeps the flag set.
         if (wr_tx && tx_full)
            tx_ovf <= 1'b1;
         else if (wr_status && WDATA[STAT_TX_OVF])
            tx_ovf <= 1'b0;

         if (rd_rx && rx_empty)
            rx_udf <= 1'b1;
         else if (wr_status && WDATA[STAT_RX_UDF])
            rx_udf <= 1'b0;
      end
   end

   // ---------------------------------------------------- CTRL / SCRATCH
   logic [1:0]  irq_en;
   logic [31:0] scratch;

`ifdef SLAVE_MAILBOX_IRQ_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         irq_en <= 2'b00;
         IRQ    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= WDATA[CTRL_ERR_IRQ_EN:CTRL_RX_IRQ_EN];
         IRQ <= (irq_en[0] && !rx_empty) || (irq_en[1] && (tx_ovf || rx_udf));
      end
   end
`else
   assign irq_en = 2'b00;
`endif

   always_ff @(posedge CLK) begin
      if (RST) scratch <= '0;
      else if (wr_scratch) scratch <= WDATA;
   end

   // ------------------------------------------------------------ STATUS
   status_t status;

   // NOTE: every field gets a default before conditional logic so the
   // combinational block can never infer a latch.
   always_comb begin
      status          = '0;
      status.tx_empty = tx_empty;
      status.tx_full  = tx_full;
      status.rx_empty = rx_empty;
      status.rx_full  = rx_full;
      status.tx_ovf   = tx_ovf;
      status.rx_udf   = rx_udf;
      status.tx_count = 8'(tx_count);
      status.rx_count = 8'(rx_count);
   end

   // -------------------------------------------------------- read mux
   // Reads see pre-edge state, so a STATUS read never reflects the same
   // cycle's push/pop/W1C. Flush bits are self-clearing and read back as 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RDATA <= '0;
      end else if (RE) begin
         unique case (RADDR)
            A_CTRL:    RDATA <= {22'd0, irq_en, 8'd0};
            A_STATUS:  RDATA <= status;
            A_RX_DATA: RDATA <= rx_empty ? 32'd0 : rx_head;
            A_SCRATCH: RDATA <= scratch;
            default:   RDATA <= '0;
         endcase
      end
   end

endmodule
